sobel_rgb_axis_frame_seq: RTL and testbench
===========================================

Name: sobel_rgb_axis_frame_seq

Overview:
Frame sequencer that sits directly downstream of the unsigned 31x31->62 multiplier in the sobel_rgb_axis datapath. It drives the multiplier operands (rows, cols), registers the 62-bit pixel total, and then gates a 24-bit RGB AXI-Stream pixel flow for exactly that many beats. It generates TUSER (start of frame) and TLAST (end of line). It gives the Sobel core a framed stream and an ap_start/ap_done/ap_idle control handshake.

Parameters:
DATA_W, 24, pixel width in bits (RGB888)
DIM_W, 31, width of the row and column configuration values; also the multiplier operand width
TOT_W, 62, width of the product and pixel counter (2*DIM_W)

Ports:
ap_clk  in  1  clock; all logic on the rising edge
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  start-frame request; sampled only in IDLE
ap_done  out  1  one-cycle pulse when the frame completes
ap_idle  out  1  high in IDLE
cfg_rows  in  DIM_W  frame height; latched on accepted start
cfg_cols  in  DIM_W  frame width; latched on accepted start
mul_din0  out  DIM_W  multiplier operand 0 = latched rows
mul_din1  out  DIM_W  multiplier operand 1 = latched cols
mul_dout  in  TOT_W  combinational product from the multiplier
pix_total  out  TOT_W  registered rows*cols; held until the next start
s_axis_tdata  in  DATA_W  input pixel
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_W  output pixel
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tuser  out  1  first pixel of the frame
m_axis_tlast  out  1  last pixel of each line

Behaviour:
- Reset (asynchronous, ap_rst_n=0):
  - state=IDLE; ap_idle=1; ap_done=0.
  - rows_r, cols_r, pix_total, col_cnt, pix_cnt all reset to 0.
  - s_axis_tready=0, m_axis_tvalid=0.
  - Asserting reset mid-frame abandons the frame. No ap_done is issued. Pixels already transferred are not replayed.
- States: IDLE, MUL, STREAM, DONE.
- IDLE -> MUL:
  - Taken when ap_start=1.
  - Latch cfg_rows into rows_r and cfg_cols into cols_r. Clear col_cnt and pix_cnt.
  - ap_idle goes low on the next cycle.
- MUL (exactly 1 cycle):
  - mul_din0=rows_r and mul_din1=cols_r are driven continuously from the registers.
  - pix_total <= mul_dout, zero-extended unsigned.
  - If rows_r==0 or cols_r==0, go to DONE (empty frame, zero beats). Otherwise go to STREAM.
- STREAM (combinational pass-through, no buffering):
  - m_axis_tvalid = s_axis_tvalid; s_axis_tready = m_axis_tready; m_axis_tdata = s_axis_tdata.
  - m_axis_tuser = (pix_cnt==0).
  - m_axis_tlast = (col_cnt==cols_r-1).
  - A beat transfers when s_axis_tvalid and m_axis_tready are both high. On a beat:
    - pix_cnt increments.
    - col_cnt increments, wrapping to 0 after cols_r-1.
  - The beat with pix_cnt==pix_total-1 is the last beat of the frame; go to DONE after it.
  - tvalid/tready are 0 in every state other than STREAM, so no beat is accepted outside a frame.
- DONE (1 cycle): ap_done=1, then go to IDLE.
- Minimum latency: accepted ap_start to the first possible beat is 2 cycles. Last beat to the ap_done pulse is 1 cycle.
- ap_start while busy (MUL/STREAM/DONE) is ignored. cfg_* changes mid-frame have no effect.
- Arithmetic:
  - All quantities are unsigned.
  - pix_cnt is TOT_W wide and cannot overflow, since the maximum is (2^31-1)^2.
  - The cols_r-1 comparison is evaluated only when cols_r>=1.
- Frame geometry is purely beat-counted. Upstream TLAST, if any, is not consumed.

Test Plan:
- rows=3, cols=4, continuous valid/ready:
  - pix_total=12; exactly 12 beats.
  - tuser only on beat 0; tlast on beats 3, 7, 11.
  - ap_done pulses 1 cycle after beat 11; ap_idle returns high.
- Same 3x4 frame with random tvalid/tready gaps (about 50%):
  - Identical data order and tuser/tlast positions; 12 beats.
  - No beat transfers while either signal is low.
- rows=0, cols=5:
  - MUL -> DONE; zero beats; s_axis_tready stays 0.
  - ap_done pulses 2 cycles after ap_start; pix_total=0.
- rows=cols=0x7FFFFFFF, multiplier stub returning the true product:
  - pix_total=0x3FFFFFFF00000001.
  - Check the mul_din0/mul_din1 values; abort via reset after 100 beats.
- ap_rst_n low after beat 5 of a 2x4 frame:
  - All outputs return to reset values immediately; no ap_done.
  - A new 2x4 start yields tuser on its first beat and 8 beats total.
- ap_start held high with cfg changes during STREAM:
  - The current frame keeps its latched dimensions.
  - The next frame starts the cycle after DONE with the new cfg values.

Source files
------------

// File: rtl/sobel_rgb_axis_frame_seq.sv
// Frame sequencer for the sobel_rgb_axis datapath: latches frame geometry, sizes the frame
// through the external multiplier, then gates an RGB AXI-Stream for exactly rows*cols beats.
module sobel_rgb_axis_frame_seq #(
   parameter int DATA_W = 24,
   parameter int DIM_W  = 31,
   parameter int TOT_W  = 62
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   // control handshake
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   // frame geometry
   input  logic [DIM_W-1:0]  cfg_rows,
   input  logic [DIM_W-1:0]  cfg_cols,
   // external multiplier
   output logic [DIM_W-1:0]  mul_din0,
   output logic [DIM_W-1:0]  mul_din1,
   input  logic [TOT_W-1:0]  mul_dout,
   output logic [TOT_W-1:0]  pix_total,
   // pixel input
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   // pixel output
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tuser,
   output logic              m_axis_tlast,
   // debug view of the sequencer state
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_MUL    = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]       state_q,     state_d;
   logic [DIM_W-1:0] rows_q,      rows_d;
   logic [DIM_W-1:0] cols_q,      cols_d;
   logic [TOT_W-1:0] pix_total_q, pix_total_d;
   logic [DIM_W-1:0] col_cnt_q,   col_cnt_d;
   logic [TOT_W-1:0] pix_cnt_q,   pix_cnt_d;

   logic in_stream;
   logic beat;
   logic last_col;
   logic last_pix;
   logic empty_frame;

   // Handshake: a beat transfers on a rising edge where the sequencer is in STREAM and both
   // s_axis_tvalid and m_axis_tready are high; outside STREAM valid and ready are forced low.
   assign in_stream   = (state_q == ST_STREAM);
   assign beat        = in_stream && s_axis_tvalid && m_axis_tready;

   // Only meaningful in STREAM, where cols_q and pix_total_q are both known to be non-zero.
   assign last_col    = (col_cnt_q == (cols_q - DIM_W'(1)));
   assign last_pix    = (pix_cnt_q == (pix_total_q - TOT_W'(1)));
   assign empty_frame = (rows_q == '0) || (cols_q == '0);

   always_comb begin
      state_d     = state_q;
      rows_d      = rows_q;
      cols_d      = cols_q;
      pix_total_d = pix_total_q;
      col_cnt_d   = col_cnt_q;
      pix_cnt_d   = pix_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (ap_start) begin
               rows_d    = cfg_rows;
               cols_d    = cfg_cols;
               col_cnt_d = '0;
               pix_cnt_d = '0;
               state_d   = ST_MUL;
            end
         end

         ST_MUL: begin
            pix_total_d = mul_dout;
            state_d     = empty_frame ? ST_DONE : ST_STREAM;
         end

         ST_STREAM: begin
            if (beat) begin
               pix_cnt_d = pix_cnt_q + TOT_W'(1);
               col_cnt_d = last_col ? '0 : (col_cnt_q + DIM_W'(1));
               if (last_pix) begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= ST_IDLE;
         rows_q      <= '0;
         cols_q      <= '0;
         pix_total_q <= '0;
         col_cnt_q   <= '0;
         pix_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         cols_q      <= cols_d;
         pix_total_q <= pix_total_d;
         col_cnt_q   <= col_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
      end
   end

   assign ap_idle       = (state_q == ST_IDLE);
   assign ap_done       = (state_q == ST_DONE);
   assign mul_din0      = rows_q;
   assign mul_din1      = cols_q;
   assign pix_total     = pix_total_q;
   assign dbg_state     = state_q;

   // Pure pass-through while streaming; nothing is buffered in this block.
   assign m_axis_tvalid = in_stream && s_axis_tvalid;
   assign s_axis_tready = in_stream && m_axis_tready;
   assign m_axis_tdata  = in_stream ? s_axis_tdata : '0;
   assign m_axis_tuser  = in_stream && (pix_cnt_q == '0);
   assign m_axis_tlast  = in_stream && last_col;

endmodule

// File: tb/tb_sobel_rgb_axis_frame_seq.sv
// Bench for sobel_rgb_axis_frame_seq: randomized pixel stream and handshake gaps, checked by a
// scoreboard fed from a frame-level model of beat order, tuser and tlast.
module tb_sobel_rgb_axis_frame_seq;

   localparam int DATA_W       = 24;
   localparam int DIM_W        = 31;
   localparam int TOT_W        = 62;
   localparam int BEAT_TIMEOUT = 200;

   logic              ap_clk;
   logic              ap_rst_n;
   logic              ap_start;
   logic              ap_done;
   logic              ap_idle;
   logic [DIM_W-1:0]  cfg_rows;
   logic [DIM_W-1:0]  cfg_cols;
   logic [DIM_W-1:0]  mul_din0;
   logic [DIM_W-1:0]  mul_din1;
   logic [TOT_W-1:0]  mul_dout;
   logic [TOT_W-1:0]  pix_total;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tuser;
   logic              m_axis_tlast;
   logic [1:0]        dbg_state;

   // expected beat = {tuser, tlast, tdata}
   logic [DATA_W+1:0] exp_q[$];
   logic [DATA_W+1:0] mon_exp;

   int     n_cmp;
   int     n_err;
   longint beats_seen;
   logic   gaps;

   sobel_rgb_axis_frame_seq #(
      .DATA_W(DATA_W),
      .DIM_W (DIM_W),
      .TOT_W (TOT_W)
   ) dut (
      .ap_clk       (ap_clk),
      .ap_rst_n     (ap_rst_n),
      .ap_start     (ap_start),
      .ap_done      (ap_done),
      .ap_idle      (ap_idle),
      .cfg_rows     (cfg_rows),
      .cfg_cols     (cfg_cols),
      .mul_din0     (mul_din0),
      .mul_din1     (mul_din1),
      .mul_dout     (mul_dout),
      .pix_total    (pix_total),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tlast (m_axis_tlast),
      .dbg_state    (dbg_state)
   );

   // multiplier stub returning the true product
   assign mul_dout = TOT_W'(mul_din0) * TOT_W'(mul_din1);

   // ---------------- clock / reset ----------------
   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic reset_check();
      ap_rst_n      = 1'b0;
      s_axis_tvalid = 1'b0;
      ap_start      = 1'b0;
      #1;
      check("rst_ap_idle",   ap_idle,       1);
      check("rst_ap_done",   ap_done,       0);
      check("rst_tready",    s_axis_tready, 0);
      check("rst_tvalid",    m_axis_tvalid, 0);
      check("rst_pix_total", pix_total,     0);
      check("rst_mul_din0",  mul_din0,      0);
      check("rst_mul_din1",  mul_din1,      0);
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      check("post_rst_no_done", ap_done, 0);
      check("post_rst_idle",    ap_idle, 1);
   endtask

   // ---------------- downstream ready driver ----------------
   initial begin
      m_axis_tready = 1'b0;
      forever begin
         @(posedge ap_clk);
         #1;
         m_axis_tready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge ap_clk) begin
      if (ap_rst_n && m_axis_tvalid && m_axis_tready) begin
         beats_seen++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got tdata 0x%0h with no beat expected (t=%0t)",
                     m_axis_tdata, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            check("beat_tdata",    m_axis_tdata,  mon_exp[DATA_W-1:0]);
            check("beat_tuser",    m_axis_tuser,  mon_exp[DATA_W+1]);
            check("beat_tlast",    m_axis_tlast,  mon_exp[DATA_W]);
            check("beat_tready",   s_axis_tready, 1);
         end
      end
   end

   // ---------------- driver: one frame ----------------
   // Entered and left just after a rising edge with the DUT in IDLE (unless truncated by max_beats).
   task automatic run_frame(input logic [DIM_W-1:0] rows, input logic [DIM_W-1:0] cols,
                            input longint max_beats, input bit hold,
                            input logic [DIM_W-1:0] nrows, input logic [DIM_W-1:0] ncols);
      logic [TOT_W-1:0] total;
      longint unsigned  n_beats;
      longint           start_seen;
      int               wait_cyc;
      bit               accepted;

      total = TOT_W'(rows) * TOT_W'(cols);
      check("idle_before_start", ap_idle, 1);
      cfg_rows      = rows;
      cfg_cols      = cols;
      ap_start      = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DATA_W'($urandom);
      @(posedge ap_clk);
      #1;
      if (hold) begin
         cfg_rows = nrows;
         cfg_cols = ncols;
      end else begin
         ap_start = 1'b0;
      end
      check("mul_din0",     mul_din0,      rows);
      check("mul_din1",     mul_din1,      cols);
      check("mul_idle_low", ap_idle,       0);
      check("mul_no_done",  ap_done,       0);
      check("mul_tready",   s_axis_tready, 0);
      @(posedge ap_clk);
      #1;
      check("pix_total", pix_total, total);

      if (total == 0) begin
         check("empty_done",   ap_done,       1);
         check("empty_tready", s_axis_tready, 0);
         check("empty_tvalid", m_axis_tvalid, 0);
         s_axis_tvalid = 1'b0;
         @(posedge ap_clk);
         #1;
         check("empty_done_clr", ap_done, 0);
         check("empty_idle",     ap_idle, 1);
         return;
      end

      start_seen = beats_seen;
      n_beats    = (max_beats > 0 && total > TOT_W'(max_beats)) ? longint'(max_beats) : total;
      for (longint unsigned k = 0; k < n_beats; k++) begin
         s_axis_tdata = DATA_W'($urandom);
         exp_q.push_back({(k == 0), ((k % cols) == (cols - 1)), s_axis_tdata});
         accepted = 1'b0;
         wait_cyc = 0;
         while (!accepted && wait_cyc < BEAT_TIMEOUT) begin
            s_axis_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge ap_clk);
            accepted = s_axis_tvalid && s_axis_tready;
            @(posedge ap_clk);
            #1;
            wait_cyc++;
         end
         if (!accepted) begin
            check("beat_timeout", 0, 1);
            s_axis_tvalid = 1'b0;
            exp_q.delete();
            return;
         end
      end
      s_axis_tvalid = 1'b0;
      check("beat_count",    beats_seen - start_seen, n_beats);
      check("exp_q_drained", exp_q.size(),            0);
      if (n_beats < total) return;

      check("done_pulse",    ap_done, 1);
      check("done_not_idle", ap_idle, 0);
      @(posedge ap_clk);
      #1;
      check("done_clr",    ap_done, 0);
      check("idle_return", ap_idle, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_cmp         = 0;
      n_err         = 0;
      beats_seen    = 0;
      gaps          = 1'b0;
      ap_rst_n      = 1'b0;
      ap_start      = 1'b0;
      cfg_rows      = '0;
      cfg_cols      = '0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;

      reset_check();

      // 3x4, continuous flow
      run_frame(3, 4, 0, 0, 0, 0);
      repeat (2) @(posedge ap_clk);
      #1;

      // 3x4 with random valid/ready gaps
      gaps = 1'b1;
      run_frame(3, 4, 0, 0, 0, 0);
      gaps = 1'b0;
      repeat (2) @(posedge ap_clk);
      #1;

      // empty frames
      run_frame(0, 5, 0, 0, 0, 0);
      run_frame(5, 0, 0, 0, 0, 0);

      // maximum geometry, aborted by reset after 100 beats
      run_frame(31'h7FFF_FFFF, 31'h7FFF_FFFF, 100, 0, 0, 0);
      check("max_pix_total", pix_total, 62'h3FFF_FFFF_0000_0001);
      reset_check();

      // reset after beat 5 of a 2x4 frame, then a clean 2x4 frame
      run_frame(2, 4, 6, 0, 0, 0);
      reset_check();
      run_frame(2, 4, 0, 0, 0, 0);

      // ap_start held with cfg changed mid-frame: next frame picks up the new geometry
      run_frame(2, 3, 0, 1, 3, 2);
      run_frame(3, 2, 0, 0, 0, 0);

      // random small frames with random gaps
      for (int i = 0; i < 6; i++) begin
         gaps = 1'($urandom_range(0, 1));
         run_frame(DIM_W'($urandom_range(1, 5)), DIM_W'($urandom_range(1, 5)), 0, 0, 0, 0);
         @(posedge ap_clk);
         #1;
      end
      gaps = 1'b0;

      repeat (2) @(posedge ap_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
